pulse_sweep_ctrl: RTL

PULSE_SWEEP_CTRL -- requirements
Module: pulse_sweep_ctrl

---
 rtl/pulse_sweep_ctrl.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/pulse_sweep_ctrl.sv
// pulse_sweep_ctrl
//
// Steps a signal generator through a small table of pulse high/low times.
// When idle, the manual base values pass through to tph/tpl with one cycle of
// latency. A start pulse arms a sweep. The first signal_cycle after arming
// loads table entry 0. After that, each entry is held for max(dwell,1)
// generator periods, and then the next entry is loaded. The sweep ends in
// DONE, or wraps around when loop_en is set.
//
// Optional feature:
//   PULSE_SWEEP_PINGPONG_EN - while looping, reverse direction at both ends of
//                             the table (0,1,..,N-1,N-2,..,0,1,..) instead of
//                             wrapping from N-1 back to 0.
//
// Parameters:
//   NUM_STEPS - sweep table depth (power of two, 2..8)
//   DWELL_W   - width of the dwell input and the dwell counter
//
// Ports:
//   clk, reset_n             - clock, asynchronous active-low reset
//   start, stop              - one-cycle pulses: arm a sweep / abort to idle
//   loop_en                  - 1 = repeat sweep, 0 = single pass
//   dwell                    - generator periods per step (0 behaves as 1)
//   signal_cycle             - one-cycle pulse at each generator period end
//   base_tph, base_tpl       - manual pulse values used while idle
//   wr_en/wr_addr/wr_tph/wr_tpl - table write port, usable in any state
//   tph, tpl                 - pulse values driven to the generator
//   tp_load                  - one-cycle pulse when tph/tpl take a table entry
//   step                     - current table index
//   busy, done, fsm_state    - status (IDLE=0, ARM=1, RUN=2, DONE=3)

module pulse_sweep_ctrl #(
  parameter int unsigned NUM_STEPS = 4,
  parameter int unsigned DWELL_W   = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         loop_en,
  input  logic [DWELL_W-1:0]           dwell,
  input  logic                         signal_cycle,
  input  logic [15:0]                  base_tph,
  input  logic [15:0]                  base_tpl,
  input  logic                         wr_en,
  input  logic [$clog2(NUM_STEPS)-1:0] wr_addr,
  input  logic [15:0]                  wr_tph,
  input  logic [15:0]                  wr_tpl,
  output logic [15:0]                  tph,
  output logic [15:0]                  tpl,
  output logic                         tp_load,
  output logic [2:0]                   step,
  output logic                         busy,
  output logic                         done,
  output logic [1:0]                   fsm_state
);

  localparam int unsigned STEP_W = $clog2(NUM_STEPS);
  localparam logic [STEP_W-1:0] LastStep = STEP_W'(NUM_STEPS - 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StArm  = 2'd1,
    StRun  = 2'd2,
    StDone = 2'd3
  } state_e;

  state_e              state_q;
  logic [STEP_W-1:0]   step_q;
  logic [DWELL_W-1:0]  count_q;
  logic [15:0]         tph_q;
  logic [15:0]         tpl_q;
  logic                tp_load_q;
  logic                busy_q;
  logic                done_q;

  logic [15:0]         tab_tph_q [NUM_STEPS];
  logic [15:0]         tab_tpl_q [NUM_STEPS];

  // Dwell bookkeeping and the index the sweep advances to next.
  logic [DWELL_W-1:0]  dwell_eff;
  logic [DWELL_W:0]    count_inc;
  logic                dwell_hit;
  logic [STEP_W-1:0]   adv_idx;
  logic                adv_finish;

`ifdef PULSE_SWEEP_PINGPONG_EN
  logic                dir_down_q;
  logic                dir_down_d;
`endif

  always_comb begin
    dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;
    count_inc = {1'b0, count_q} + (DWELL_W + 1)'(1);
    // >= rather than == so that a dwell lowered below the running count
    // advances on the very next period instead of waiting for a wrap.
    dwell_hit = (count_inc >= {1'b0, dwell_eff});
  end

`ifdef PULSE_SWEEP_PINGPONG_EN
  always_comb begin
    adv_idx    = step_q;
    adv_finish = 1'b0;
    dir_down_d = dir_down_q;
    if (dir_down_q) begin
      if (step_q == '0) begin
        if (loop_en) begin
          dir_down_d = 1'b0;
          adv_idx    = STEP_W'(1);
        end else begin
          adv_finish = 1'b1;
        end
      end else begin
        adv_idx = step_q - STEP_W'(1);
      end
    end else begin
      if (step_q == LastStep) begin
        if (loop_en) begin
          dir_down_d = 1'b1;
          adv_idx    = LastStep - STEP_W'(1);
        end else begin
          adv_finish = 1'b1;
        end
      end else begin
        adv_idx = step_q + STEP_W'(1);
      end
    end
  end
`else
  always_comb begin
    adv_idx    = step_q + STEP_W'(1);
    adv_finish = 1'b0;
    if (step_q == LastStep) begin
      adv_idx    = '0;
      adv_finish = !loop_en;
    end
  end
`endif

  // Sweep table. It is written independently of the FSM. Loads copy an entry
  // into tph_q/tpl_q, so rewriting the active entry has no effect on the
  // outputs until that entry is loaded again.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(NUM_STEPS); i++) begin
        tab_tph_q[i] <= '0;
        tab_tpl_q[i] <= '0;
      end
    end else if (wr_en) begin
      tab_tph_q[wr_addr] <= wr_tph;
      tab_tpl_q[wr_addr] <= wr_tpl;
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      step_q    <= '0;
      count_q   <= '0;
      tph_q     <= '0;
      tpl_q     <= '0;
      tp_load_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef PULSE_SWEEP_PINGPONG_EN
      dir_down_q <= 1'b0;
`endif
    end else begin
      tp_load_q <= 1'b0;
      if (stop) begin
        // Abort has priority over start and signal_cycle in every state.
        state_q <= StIdle;
        step_q  <= '0;
        count_q <= '0;
        tph_q   <= base_tph;
        tpl_q   <= base_tpl;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            tph_q <= base_tph;
            tpl_q <= base_tpl;
            if (start) begin
              state_q <= StArm;
              step_q  <= '0;
              count_q <= '0;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
`ifdef PULSE_SWEEP_PINGPONG_EN
              dir_down_q <= 1'b0;
`endif
            end
          end

          StArm: begin
            // Wait for a period boundary so that the first entry starts on a
            // whole generator period.
            if (signal_cycle) begin
              state_q   <= StRun;
              count_q   <= '0;
              tph_q     <= tab_tph_q[0];
              tpl_q     <= tab_tpl_q[0];
              tp_load_q <= 1'b1;
            end
          end

          StRun: begin
            if (signal_cycle) begin
              if (dwell_hit) begin
                count_q <= '0;
                if (adv_finish) begin
                  // Single pass complete: keep the last entry on the outputs.
                  state_q <= StDone;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                end else begin
                  step_q    <= adv_idx;
                  tph_q     <= tab_tph_q[adv_idx];
                  tpl_q     <= tab_tpl_q[adv_idx];
                  tp_load_q <= 1'b1;
`ifdef PULSE_SWEEP_PINGPONG_EN
                  dir_down_q <= dir_down_d;
`endif
                end
              end else begin
                count_q <= count_inc[DWELL_W-1:0];
              end
            end
          end

          StDone: begin
            if (start) begin
              state_q <= StArm;
              step_q  <= '0;
              count_q <= '0;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
`ifdef PULSE_SWEEP_PINGPONG_EN
              dir_down_q <= 1'b0;
`endif
            end
          end

          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign tph       = tph_q;
  assign tpl       = tpl_q;
  assign tp_load   = tp_load_q;
  assign step      = 3'(step_q);
  assign busy      = busy_q;
  assign done      = done_q;
  assign fsm_state = state_q;

endmodule
